// File: rtl/phase_ack_pkg.sv
// phase_ack_pkg: shared dual-rail codes, slot state encoding and code helpers
//   PH_NULL/PH_D0/PH_D1/PH_INV : dual-rail token codes seen on the phase ring
//   slot_state_t               : per-slot handshake state
//   is_data()                  : true for DATA0/DATA1 codes
package phase_ack_pkg;
  localparam logic [1:0] PH_NULL = 2'b00;
  localparam logic [1:0] PH_D0   = 2'b01;
  localparam logic [1:0] PH_D1   = 2'b10;
  localparam logic [1:0] PH_INV  = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, ACK_HI, ACK_LO} slot_state_t;
  function automatic logic is_data(input logic [1:0] c);
    return c == PH_D0 || c == PH_D1;
  endfunction
endpackage

// File: rtl/phase_slot_fsm.sv
// phase_slot_fsm: one ring phase slot - synchronizer, debounce, handshake FSM, done capture, timeout
//   clk, rst            : clock, asynchronous active-high reset
//   i_enable            : allows IDLE to accept a new token
//   i_ph[1:0]           : asynchronous dual-rail token
//   i_done[N-1:0]       : consumer completion pulses
//   o_evt[N-1:0]        : token-arrived pulse to every consumer
//   o_tok_val           : data bit of the last accepted token
//   o_ack               : acknowledge to the ring (high in ACK_HI)
//   o_busy              : slot not in IDLE
//   o_err_code          : invalid code or code change while BUSY (this cycle)
//   o_err_timeout       : slot has waited TIMEOUT cycles in BUSY/ACK_HI (one pulse)
//   o_ack_lo_entry      : slot is entering ACK_LO at the next edge
module phase_slot_fsm
  import phase_ack_pkg::*;
#(
  parameter int N           = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_enable,
  input  logic [1:0]   i_ph,
  input  logic [N-1:0] i_done,
  output logic [N-1:0] o_evt,
  output logic         o_tok_val,
  output logic         o_ack,
  output logic         o_busy,
  output logic         o_err_code,
  output logic         o_err_timeout,
  output logic         o_ack_lo_entry
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] T_HIT = CW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]    r_prev;
  slot_state_t   r_state, w_next;
  logic [N-1:0]  r_cap, r_evt;
  logic          r_tok;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_code;
  logic          w_stable, w_inv, w_data, w_null, w_all_done, w_accept, w_timing;

  assign w_code     = r_sync[SYNC_STAGES-1];
  // a code only counts once two consecutive synchronized samples agree
  assign w_stable   = w_code == r_prev;
  assign w_inv      = w_stable && w_code == PH_INV;
  assign w_data     = w_stable && is_data(w_code);
  assign w_null     = w_stable && w_code == PH_NULL;
  assign w_all_done = &(r_cap | i_done);
  assign w_accept   = r_state == IDLE && w_next == BUSY;
  assign w_timing   = r_state == BUSY || r_state == ACK_HI;
  assign o_evt      = r_evt;
  assign o_tok_val  = r_tok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // an INVALID code freezes the slot wherever it is
  always_comb begin
    w_next = w_inv                                   ? r_state :
             (r_state == IDLE && w_data && i_enable) ? BUSY    :
             (r_state == BUSY && w_all_done)         ? ACK_HI  :
             (r_state == ACK_HI && w_null)           ? ACK_LO  :
             (r_state == ACK_LO)                     ? IDLE    : r_state;
  end

  always_comb begin
    o_ack          = r_state == ACK_HI;
    o_busy         = r_state != IDLE;
    o_err_code     = w_inv || (r_state == BUSY && w_data && w_code[1] != r_tok);
    o_err_timeout  = w_timing && r_cnt == T_HIT;
    o_ack_lo_entry = r_state == ACK_HI && w_next == ACK_LO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= PH_NULL;
      r_cap  <= '0;
      r_evt  <= '0;
      r_tok  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ph};
      r_prev <= w_code;
      // capture is zero outside BUSY, so it starts clean on every new token
      r_cap  <= (r_state == BUSY) ? (r_cap | i_done) : '0;
      r_evt  <= {N{w_accept}};
      r_tok  <= w_accept ? w_code[1] : r_tok;
      // saturates at TIMEOUT so the timeout pulse fires once per wait
      r_cnt  <= (w_next != r_state)          ? '0            :
                (w_timing && r_cnt != T_MAX) ? r_cnt + 1'b1  : r_cnt;
    end
  end
endmodule

// File: rtl/phase_ack_ctrl.sv
// phase_ack_ctrl: sequences the three-stage dual-rail phase ring and its acknowledges
//   clk, rst                 : clock, asynchronous active-high reset
//   enable                   : lets idle slots accept tokens
//   clear_err                : clears the sticky error flags
//   ph0_i/ph1_i/ph2_i        : asynchronous dual-rail phase tokens
//   evt0_o/evt1_o/evt2_o     : token-arrived pulses to the consumers
//   tok_val_o                : data bit last accepted per slot
//   done0_i/done1_i/done2_i  : consumer completion pulses
//   ack_ph01_o..ack_ph03_o   : ring ackInPH01..03 (slot 0)
//   ack_ph1_o, ack_ph2_o     : ring ackInPH1, ackInPH2
//   rev_cnt_o                : completed revolutions (slot 2 entering ACK_LO)
//   err_code_o, err_timeout_o: sticky error flags
//   slot_busy_o              : per-slot not-IDLE
module phase_ack_ctrl
  import phase_ack_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear_err,
  input  logic [1:0]       ph0_i,
  input  logic [1:0]       ph1_i,
  input  logic [1:0]       ph2_i,
  output logic [2:0]       evt0_o,
  output logic             evt1_o,
  output logic             evt2_o,
  output logic [2:0]       tok_val_o,
  input  logic [2:0]       done0_i,
  input  logic             done1_i,
  input  logic             done2_i,
  output logic             ack_ph01_o,
  output logic             ack_ph02_o,
  output logic             ack_ph03_o,
  output logic             ack_ph1_o,
  output logic             ack_ph2_o,
  output logic [CNT_W-1:0] rev_cnt_o,
  output logic             err_code_o,
  output logic             err_timeout_o,
  output logic [2:0]       slot_busy_o
);
  logic [2:0]       w_err_code, w_err_to;
  logic             w_ack0, w_rev_tick;
  logic [1:0]       w_lo_unused;
  logic [CNT_W-1:0] r_rev;
  logic             r_err_code, r_err_to;

  phase_slot_fsm #(.N(3), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_slot0 (
    .clk(clk), .rst(rst), .i_enable(enable), .i_ph(ph0_i), .i_done(done0_i),
    .o_evt(evt0_o), .o_tok_val(tok_val_o[0]), .o_ack(w_ack0), .o_busy(slot_busy_o[0]),
    .o_err_code(w_err_code[0]), .o_err_timeout(w_err_to[0]), .o_ack_lo_entry(w_lo_unused[0])
  );

  phase_slot_fsm #(.N(1), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_slot1 (
    .clk(clk), .rst(rst), .i_enable(enable), .i_ph(ph1_i), .i_done(done1_i),
    .o_evt(evt1_o), .o_tok_val(tok_val_o[1]), .o_ack(ack_ph1_o), .o_busy(slot_busy_o[1]),
    .o_err_code(w_err_code[1]), .o_err_timeout(w_err_to[1]), .o_ack_lo_entry(w_lo_unused[1])
  );

  phase_slot_fsm #(.N(1), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_slot2 (
    .clk(clk), .rst(rst), .i_enable(enable), .i_ph(ph2_i), .i_done(done2_i),
    .o_evt(evt2_o), .o_tok_val(tok_val_o[2]), .o_ack(ack_ph2_o), .o_busy(slot_busy_o[2]),
    .o_err_code(w_err_code[2]), .o_err_timeout(w_err_to[2]), .o_ack_lo_entry(w_rev_tick)
  );

  assign ack_ph01_o    = w_ack0;
  assign ack_ph02_o    = w_ack0;
  assign ack_ph03_o    = w_ack0;
  assign rev_cnt_o     = r_rev;
  assign err_code_o    = r_err_code;
  assign err_timeout_o = r_err_to;

  // a fresh error event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rev      <= '0;
      r_err_code <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_rev      <= r_rev + CNT_W'(w_rev_tick);
      r_err_code <= (|w_err_code) || (r_err_code && !clear_err);
      r_err_to   <= (|w_err_to) || (r_err_to && !clear_err);
    end
  end
endmodule

// File: tb/tb_phase_ack_ctrl.sv
// tb_phase_ack_ctrl: scoreboard bench for phase_ack_ctrl with a ring-level reference model
module tb_phase_ack_ctrl;
  localparam int K_EVT = 0, K_RISE = 1, K_FALL = 2;

  typedef struct { int s; int k; int v; int c; } ev_t;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, clear_err = 1'b0;
  logic [1:0] ph0 = 2'b00, ph1 = 2'b00, ph2 = 2'b00;
  logic [2:0] done0 = 3'b000;
  logic       done1 = 1'b0, done2 = 1'b0;
  logic [2:0] evt0, tok_val, slot_busy;
  logic       evt1, evt2, ack01, ack02, ack03, ack1, ack2, err_code, err_to;
  logic [3:0] rev_cnt;

  int   cyc = 0, n_cmp = 0, n_err = 0, model_rev = 0, prev_rev = 0;
  ev_t  exp_q[$];
  int   rev_v[$], rev_c[$];
  logic [2:0] prev_ack [3] = '{3'b000, 3'b000, 3'b000};

  phase_ack_ctrl #(.SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
    .ph0_i(ph0), .ph1_i(ph1), .ph2_i(ph2),
    .evt0_o(evt0), .evt1_o(evt1), .evt2_o(evt2), .tok_val_o(tok_val),
    .done0_i(done0), .done1_i(done1), .done2_i(done2),
    .ack_ph01_o(ack01), .ack_ph02_o(ack02), .ack_ph03_o(ack03),
    .ack_ph1_o(ack1), .ack_ph2_o(ack2), .rev_cnt_o(rev_cnt),
    .err_code_o(err_code), .err_timeout_o(err_to), .slot_busy_o(slot_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic observe(input int s, input int k, input int v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: actual slot=%0d kind=%0d val=%0d cyc=%0d required none", s, k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.s != s || e.k != k || e.v != v || e.c != cyc) begin
        n_err++;
        $display("FAIL event: actual slot=%0d kind=%0d val=%0d cyc=%0d required slot=%0d kind=%0d val=%0d cyc=%0d",
                 s, k, v, cyc, e.s, e.k, e.v, e.c);
      end
    end
  endtask

  task automatic observe_rev(input int v);
    int rv, rc;
    n_cmp++;
    if (rev_v.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_rev: actual=%0d at cyc=%0d required no change", v, cyc);
    end else begin
      rv = rev_v.pop_front();
      rc = rev_c.pop_front();
      if (rv != v || rc != cyc) begin
        n_err++;
        $display("FAIL rev_cnt: actual=%0d cyc=%0d required=%0d cyc=%0d", v, cyc, rv, rc);
      end
    end
  endtask

  // monitor: every visible evt pulse, ack edge and rev change is matched against the scoreboard
  always @(negedge clk) begin
    logic [2:0] av [3];
    logic [2:0] ev [3];
    av[0] = {ack03, ack02, ack01};
    av[1] = {2'b00, ack1};
    av[2] = {2'b00, ack2};
    ev[0] = evt0;
    ev[1] = {2'b00, evt1};
    ev[2] = {2'b00, evt2};
    if (rst) begin
      for (int s = 0; s < 3; s++) prev_ack[s] = av[s];
      prev_rev = int'(rev_cnt);
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (ev[s] != 3'b000) observe(s, K_EVT, int'(ev[s]) * 2 + int'(tok_val[s]));
        if (av[s] != prev_ack[s]) begin
          observe(s, (av[s] != 3'b000) ? K_RISE : K_FALL, int'(av[s]));
          prev_ack[s] = av[s];
        end
      end
      if (int'(rev_cnt) != prev_rev) begin
        observe_rev(int'(rev_cnt));
        prev_rev = int'(rev_cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int s, input int k, input int v, input int c);
    ev_t e;
    e.s = s; e.k = k; e.v = v; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic set_ph(input int s, input logic [1:0] v);
    case (s)
      0: ph0 = v;
      1: ph1 = v;
      default: ph2 = v;
    endcase
  endtask

  task automatic set_done(input int s, input logic [2:0] v);
    case (s)
      0: done0 = v;
      1: done1 = v[0];
      default: done2 = v[0];
    endcase
  endtask

  function automatic int fullv(input int s);
    return (s == 0) ? 7 : 1;
  endfunction

  // ring model: token reaches consumers SYNC_STAGES+2 cycles after it is driven,
  // ack rises the cycle after the last consumer finishes, falls SYNC_STAGES+2 after NULL
  task automatic do_slot(input int s, input int b, input int o0, input int o1, input int o2, input int gap);
    int c, last, n;
    int offs [3];
    logic [2:0] d;
    c = cyc;
    set_ph(s, b != 0 ? 2'b10 : 2'b01);
    push(s, K_EVT, fullv(s) * 2 + b, c + 4);
    n = (s == 0) ? 3 : 1;
    offs[0] = o0; offs[1] = o1; offs[2] = o2;
    last = 0;
    for (int i = 0; i < n; i++) if (offs[i] > last) last = offs[i];
    push(s, K_RISE, fullv(s), c + 5 + last);
    tick(4);
    for (int k = 0; k <= last; k++) begin
      d = 3'b000;
      for (int i = 0; i < n; i++) if (offs[i] == k) d[i] = 1'b1;
      set_done(s, d);
      tick(1);
    end
    set_done(s, 3'b000);
    tick(gap);
    c = cyc;
    set_ph(s, 2'b00);
    push(s, K_FALL, 0, c + 4);
    if (s == 2) begin
      model_rev = (model_rev + 1) % 16;
      rev_v.push_back(model_rev);
      rev_c.push_back(c + 4);
    end
    tick(5);
  endtask

  task automatic revolution();
    for (int s = 0; s < 3; s++)
      do_slot(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e;
    tick(3);
    chk("rst_acks", int'({ack01, ack02, ack03, ack1, ack2}), 0);
    chk("rst_evt", int'({evt0, evt1, evt2}), 0);
    chk("rst_tok", int'(tok_val), 0);
    chk("rst_rev", int'(rev_cnt), 0);
    chk("rst_err", int'({err_code, err_to}), 0);
    chk("rst_busy", int'(slot_busy), 0);
    #2 rst = 1'b0;
    tick(2);

    // slot 0 alone, completions on three separate cycles (first one on the evt cycle)
    do_slot(0, 0, 0, 2, 4, 1);
    chk("slot0_idle_after", int'(slot_busy), 0);

    // full revolution 10/01/10, then wrap the 4-bit counter
    do_slot(0, 1, 1, 1, 1, 0);
    do_slot(1, 0, 2, 0, 0, 2);
    do_slot(2, 1, 0, 0, 0, 1);
    chk("rev_one", int'(rev_cnt), model_rev);
    for (int r = 0; r < 15; r++) revolution();
    chk("rev_wrap", int'(rev_cnt), 0);
    chk("no_err_after_revs", int'({err_code, err_to}), 0);

    // invalid code on idle slot 1, clearing, and clear losing to a new error
    ph1 = 2'b11;
    tick(5);
    chk("inv_err", int'(err_code), 1);
    chk("inv_ack", int'(ack1), 0);
    chk("inv_busy", int'(slot_busy[1]), 0);
    ph1 = 2'b00;
    tick(4);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_err", int'(err_code), 0);
    ph1 = 2'b11;
    tick(3);
    chk("err_before_new", int'(err_code), 0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_vs_new", int'(err_code), 1);
    ph1 = 2'b00;
    tick(4);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_again", int'(err_code), 0);
    chk("inv_no_timeout", int'(err_to), 0);

    // timeout on slot 2, data change while BUSY, then late completion still acks
    c = cyc;
    ph2 = 2'b10;
    push(2, K_EVT, 3, c + 4);
    tick(11);
    chk("timeout_early", int'(err_to), 0);
    tick(1);
    chk("timeout_set", int'(err_to), 1);
    chk("timeout_ack_low", int'(ack2), 0);
    ph2 = 2'b01;
    tick(5);
    chk("code_change_err", int'(err_code), 1);
    ph2 = 2'b10;
    tick(4);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_both", int'({err_code, err_to}), 0);
    done2 = 1'b1;
    push(2, K_RISE, 1, cyc + 1);
    tick(1);
    done2 = 1'b0;
    tick(2);
    c = cyc;
    ph2 = 2'b00;
    push(2, K_FALL, 0, c + 4);
    model_rev = (model_rev + 1) % 16;
    rev_v.push_back(model_rev);
    rev_c.push_back(c + 4);
    tick(5);

    // enable gating
    enable = 1'b0;
    ph0 = 2'b01;
    tick(8);
    chk("en0_busy", int'(slot_busy), 0);
    enable = 1'b1;
    e = cyc;
    push(0, K_EVT, 14, e + 1);
    tick(1);
    chk("en1_busy", int'(slot_busy[0]), 1);
    done0 = 3'b111;
    push(0, K_RISE, 7, cyc + 1);
    tick(1);
    done0 = 3'b000;
    tick(1);
    c = cyc;
    ph0 = 2'b00;
    push(0, K_FALL, 0, c + 4);
    tick(5);

    // reset while slot 0 holds its acks high, token still present on release
    c = cyc;
    ph0 = 2'b10;
    push(0, K_EVT, 15, c + 4);
    tick(4);
    done0 = 3'b111;
    push(0, K_RISE, 7, cyc + 1);
    tick(1);
    done0 = 3'b000;
    tick(2);
    chk("pre_rst_ack", int'({ack01, ack02, ack03}), 7);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ack", int'({ack01, ack02, ack03, ack1, ack2}), 0);
    chk("rst_async_busy", int'(slot_busy), 0);
    chk("rst_async_rev", int'(rev_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_rev = 0;
    c = cyc;
    push(0, K_EVT, 15, c + 4);
    tick(4);
    done0 = 3'b111;
    push(0, K_RISE, 7, cyc + 1);
    tick(1);
    done0 = 3'b000;
    tick(1);
    c = cyc;
    ph0 = 2'b00;
    push(0, K_FALL, 0, c + 4);
    tick(10);

    chk("queue_drain", exp_q.size() + rev_v.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phase_ack_ctrl.md
Name: phase_ack_ctrl

Overview:
- Clocked controller that sequences the three-stage asynchronous phase ring (PH0/PH1/PH2, dual-rail 2-bit tokens).
- Synchronizes each phase token into the clock domain and signals the consumers attached to that phase.
- Collects each consumer's completion and drives the ring's external acknowledge inputs (ackInPH01..03, ackInPH1, ackInPH2) with a four-phase protocol.
- Also counts ring revolutions and flags invalid codes and stalls.

Parameters:
- SYNC_STAGES, 2: flops per synchronizer on each ph*_i bit (minimum 2).
- TIMEOUT, 1024: cycles a slot may spend in BUSY or ACK_HI before err_timeout sets.
- CNT_W, 16: width of rev_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, idle slots accept no new token, which stalls the ring.
- clear_err  in  1  synchronous clear of sticky error flags.
- ph0_i  in  2  PH0 dual-rail token from the ring (asynchronous).
- ph1_i  in  2  PH1 dual-rail token (asynchronous).
- ph2_i  in  2  PH2 dual-rail token (asynchronous).
- evt0_o  out  3  one-cycle pulse per PH0 consumer: token arrived.
- evt1_o  out  1  PH1 consumer token-arrived pulse.
- evt2_o  out  1  PH2 consumer token-arrived pulse.
- tok_val_o  out  3  decoded data bit of the token last accepted by slot 0/1/2.
- done0_i  in  3  per-consumer completion pulses for PH0.
- done1_i  in  1  completion pulse for PH1.
- done2_i  in  1  completion pulse for PH2.
- ack_ph01_o, ack_ph02_o, ack_ph03_o  out  1 each  to ring ackInPH01..03.
- ack_ph1_o  out  1  to ring ackInPH1.
- ack_ph2_o  out  1  to ring ackInPH2.
- rev_cnt_o  out  CNT_W  completed ring revolutions.
- err_code_o  out  1  sticky flag: code 2'b11 sampled.
- err_timeout_o  out  1  sticky flag: timeout occurred.
- slot_busy_o  out  3  slot n not in IDLE.

Behaviour:
- Dual-rail codes:
  - 2'b00 NULL (spacer).
  - 2'b01 DATA0.
  - 2'b10 DATA1.
  - 2'b11 INVALID.
- Each ph bit passes through a SYNC_STAGES flop synchronizer. A code is accepted only when two consecutive synchronized samples are equal (one-cycle debounce against skew between rails).
- Reset:
  - All acks, evt, tok_val, rev_cnt, errors and slot_busy are 0.
  - All slots are in IDLE.
  - Synchronizer flops clear to 0.
- Per-slot FSM, three instances, N consumers (slot 0: N=3; slots 1 and 2: N=1):
  - IDLE: on a stable DATA0/DATA1 code with enable=1, latch tok_val and pulse evt (all N bits) in the following cycle. Clear the done-capture register and go to BUSY.
  - BUSY: OR done pulses into the N-bit capture register. When all N bits are set (including the same-cycle pulse), go to ACK_HI. Acks are raised the next cycle and held; all N acks of a slot rise together.
  - ACK_HI: acks high. On a stable NULL code, go to ACK_LO.
  - ACK_LO: acks drop, then return to IDLE. Minimum IDLE dwell is one cycle.
- Done pulses outside BUSY are ignored.
- A done pulse coincident with the evt cycle counts.
- Latency from stable code to evt is 1 cycle. Latency from the last done to ack rise is 1 cycle. Latency from stable NULL to ack fall is 1 cycle.
- INVALID in any state:
  - Sets err_code.
  - The slot holds its state and acks unchanged.
  - A code change while in BUSY (e.g. DATA0 to DATA1) also sets err_code.
- Timeout:
  - Per-slot counter runs in BUSY and ACK_HI and resets on every state change.
  - When it reaches TIMEOUT-1, err_timeout sets.
  - The slot keeps waiting; nothing is forced.
- clear_err clears both errors the cycle after it is asserted. A new error event in that same cycle wins, and the flag stays set.
- rev_cnt increments on slot 2's ACK_LO entry and wraps modulo 2^CNT_W.
- enable=0 does not abort a slot that is already past IDLE.
- Reset mid-operation: acks fall immediately (asynchronously). After release, a non-NULL token still on the ring is treated as a new arrival.

Decomposition:
- Package phase_ack_pkg holds:
  - Code constants PH_NULL, PH_D0, PH_D1, PH_INV.
  - Slot state enum IDLE/BUSY/ACK_HI/ACK_LO.
  - Helper function is_data().
- Sub-module phase_slot_fsm (params N, SYNC_STAGES, TIMEOUT) contains the synchronizer, debounce, FSM, done capture and timeout. It is instantiated three times; the top level holds rev_cnt, error aggregation and port mapping.

Test Plan:
- Reset, then ph0_i=01 stable: evt0_o=3'b111 pulse 1 cycle after stability, tok_val_o[0]=0. done0_i bits pulsed on three separate cycles: ack_ph01..03 rise together 1 cycle after the third pulse. ph0_i=00: acks fall 1 cycle after stable NULL.
- Full revolution PH0, PH1, PH2 with ph codes 10/01/10 and done pulses on each: rev_cnt_o=1. Repeat 2^CNT_W times with CNT_W=4: rev_cnt_o wraps to 0.
- ph1_i=11 while slot 1 is IDLE: err_code_o=1, ack_ph1_o stays 0. clear_err pulse: flag clears the next cycle. Clear issued together with a second 11: flag stays 1.
- Token on ph2_i, done never given, TIMEOUT=8: err_timeout_o=1 after 8 cycles in BUSY. A later done2_i still gives ack_ph2_o=1.
- enable=0 with ph0_i=01: no evt, slot_busy_o=0. enable=1: evt0_o fires 1 cycle later.
- Assert rst while slot 0 is in ACK_HI: all acks 0 asynchronously. Release with ph0_i still 10: a new evt0_o pulse is issued.
